// File: rtl/core_pipelined_mem.sv
// core_pipelined_mem
//   Multi-cycle CR-CPU core. Instructions are fetched and data is accessed over
//   external req/ack memory ports, so slow or shared memories can stall the core.
//   Each instruction runs FETCH -> EXEC (-> MEM) -> FETCH. HALT stops the core
//   until the next reset.
//
// Ports
//   i_clk, i_rst_n                clock, asynchronous active-low reset
//   o_imem_req/o_imem_addr        fetch request and address (= PC)
//   i_imem_ack/i_imem_data        fetch complete, 16-bit instruction word
//   o_dmem_req/o_dmem_we          data request, 1 = STORE / 0 = LOAD
//   o_dmem_addr/o_dmem_wdata      data address (k field) and store data
//   i_dmem_ack/i_dmem_rdata       data access complete, load data
//   o_halted                      core has executed HALT
//
// Instruction word: opcode[15:12] hi[11:10] lo[9:8] k[7:0]
//   Registers: ra=0, rb=1, rc=2, rd=3.
//   Opcodes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 SHIFT, 5 MOVE, 6 LOADC, 7 JUMP,
//            8 LOAD, 9 STORE, 10 HALT, 11..15 no operation.

module core_pipelined_mem #(
  parameter int DATA_WIDTH      = 16,
  parameter int INST_ADDR_WIDTH = 8,
  parameter int DATA_ADDR_WIDTH = 8
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  output logic                       o_imem_req,
  output logic [INST_ADDR_WIDTH-1:0] o_imem_addr,
  input  logic                       i_imem_ack,
  input  logic [15:0]                i_imem_data,
  output logic                       o_dmem_req,
  output logic                       o_dmem_we,
  output logic [DATA_ADDR_WIDTH-1:0] o_dmem_addr,
  output logic [DATA_WIDTH-1:0]      o_dmem_wdata,
  input  logic                       i_dmem_ack,
  input  logic [DATA_WIDTH-1:0]      i_dmem_rdata,
  output logic                       o_halted
);

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_AND   = 4'd2;
  localparam logic [3:0] OP_OR    = 4'd3;
  localparam logic [3:0] OP_SHIFT = 4'd4;
  localparam logic [3:0] OP_MOVE  = 4'd5;
  localparam logic [3:0] OP_LOADC = 4'd6;
  localparam logic [3:0] OP_JUMP  = 4'd7;
  localparam logic [3:0] OP_LOAD  = 4'd8;
  localparam logic [3:0] OP_STORE = 4'd9;
  localparam logic [3:0] OP_HALT  = 4'd10;

  typedef enum logic [1:0] {
    ST_FETCH,
    ST_EXEC,
    ST_MEM,
    ST_HALT
  } state_t;

  state_t                      state;
  logic [INST_ADDR_WIDTH-1:0]  pc;
  logic [15:0]                 ir;
  logic [DATA_WIDTH-1:0]       regs [4];

  logic                        imem_req;
  logic                        dmem_req;
  logic                        dmem_we;
  logic [DATA_ADDR_WIDTH-1:0]  dmem_addr;
  logic [DATA_WIDTH-1:0]       dmem_wdata;
  logic                        halted;

  // Instruction fields
  logic [3:0]            opcode;
  logic [1:0]            hi;
  logic [1:0]            lo;
  logic [7:0]            k;
  logic [DATA_WIDTH-1:0] kx;

  assign opcode = ir[15:12];
  assign hi     = ir[11:10];
  assign lo     = ir[9:8];
  assign k      = ir[7:0];
  assign kx     = {{(DATA_WIDTH-8){1'b0}}, k};

  // Logical shift; a shift amount >= DATA_WIDTH yields zero by language rules.
  function automatic logic [DATA_WIDTH-1:0] shift_op(
    input logic [DATA_WIDTH-1:0] val,
    input logic [DATA_WIDTH-1:0] amt,
    input logic                  right
  );
    return right ? (val >> amt) : (val << amt);
  endfunction

  // EXEC-stage datapath: register write-back value and jump decision
  logic [DATA_WIDTH-1:0] op_a;
  logic [DATA_WIDTH-1:0] op_b;
  logic [DATA_WIDTH-1:0] shamt;
  logic [DATA_WIDTH-1:0] wr_val;
  logic                  wr_en;
  logic                  jump_taken;

  always_comb begin
    op_a       = lo[1] ? regs[1] : regs[0];
    op_b       = lo[0] ? kx : regs[2];
    shamt      = lo[1] ? kx : regs[3];
    wr_en      = 1'b0;
    wr_val     = regs[hi];
    jump_taken = 1'b0;
    case (opcode)
      OP_ADD:   begin wr_en = 1'b1; wr_val = op_a + op_b; end
      OP_SUB:   begin wr_en = 1'b1; wr_val = op_a - op_b; end
      OP_AND:   begin wr_en = 1'b1; wr_val = op_a & op_b; end
      OP_OR:    begin wr_en = 1'b1; wr_val = op_a | op_b; end
      OP_SHIFT: begin wr_en = 1'b1; wr_val = shift_op(regs[hi], shamt, lo[0]); end
      OP_MOVE:  begin wr_en = 1'b1; wr_val = regs[lo]; end
      OP_LOADC: begin
        wr_en = 1'b1;
        if (lo[0]) wr_val[15:8] = k;
        else       wr_val = kx;
      end
      OP_JUMP: begin
        case (lo)
          2'b00:   jump_taken = 1'b1;
          2'b01:   jump_taken = (regs[1] == '0);
          2'b10:   jump_taken = (regs[1] != '0);
          default: jump_taken = 1'b0;
        endcase
      end
      default: ;
    endcase
  end

  // Control FSM. Request outputs are registered and raised on entry to the
  // state that owns them, so an access costs no extra cycle; only the first
  // fetch after reset spends one idle cycle raising o_imem_req.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= ST_FETCH;
      pc         <= '0;
      ir         <= '0;
      for (int i = 0; i < 4; i++) regs[i] <= '0;
      imem_req   <= 1'b0;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      halted     <= 1'b0;
    end else begin
      case (state)
        ST_FETCH: begin
          if (!imem_req) begin
            imem_req <= 1'b1;
          end else if (i_imem_ack) begin
            ir       <= i_imem_data;
            pc       <= pc + 1'b1;
            imem_req <= 1'b0;
            state    <= ST_EXEC;
          end
        end

        ST_EXEC: begin
          state    <= ST_FETCH;
          imem_req <= 1'b1;
          if (wr_en) regs[hi] <= wr_val;
          // pc already points past this instruction; a taken jump replaces it
          if (jump_taken) pc <= regs[0][INST_ADDR_WIDTH-1:0];
          if (opcode == OP_LOAD || opcode == OP_STORE) begin
            state      <= ST_MEM;
            imem_req   <= 1'b0;
            dmem_req   <= 1'b1;
            dmem_we    <= (opcode == OP_STORE);
            dmem_addr  <= k[DATA_ADDR_WIDTH-1:0];
            dmem_wdata <= regs[hi];
          end else if (opcode == OP_HALT) begin
            state    <= ST_HALT;
            imem_req <= 1'b0;
            halted   <= 1'b1;
          end
        end

        ST_MEM: begin
          if (i_dmem_ack) begin
            dmem_req <= 1'b0;
            if (!dmem_we) regs[hi] <= i_dmem_rdata;
            state    <= ST_FETCH;
            imem_req <= 1'b1;
          end
        end

        default: ; // ST_HALT: terminal until reset
      endcase
    end
  end

  assign o_imem_req   = imem_req;
  assign o_imem_addr  = pc;
  assign o_dmem_req   = dmem_req;
  assign o_dmem_we    = dmem_we;
  assign o_dmem_addr  = dmem_addr;
  assign o_dmem_wdata = dmem_wdata;
  assign o_halted     = halted;

endmodule
